// File: rtl/pipe_control_unit_if.sv
// Bus between IF/ID decode inputs and the registered ID/EX control outputs.
// The slave modport belongs to pipe_control_unit; the master modport to whatever drives it.
interface pipe_control_unit_if #(
  parameter int OPW  = 8,
  parameter int ALUW = 4
);
  logic [OPW-1:0]  ctrlSignal;
  logic            inValid;
  logic            hazardStall;
  logic            flush;
  logic            branch;
  logic            jump;
  logic            writeEN1;
  logic            writeEN2;
  logic            ifIDFlush;
  logic            Op1Mux;
  logic            Op2Mux;
  logic            dataMemWR;
  logic            dataMemRD;
  logic            dirALUMux;
  logic            wbMUX;
  logic [ALUW-1:0] aLUControl;
  logic            stall;

  modport slave (
    input  ctrlSignal, inValid, hazardStall, flush,
    output branch, jump, writeEN1, writeEN2, ifIDFlush, Op1Mux, Op2Mux,
           dataMemWR, dataMemRD, dirALUMux, wbMUX, aLUControl, stall
  );

  modport master (
    output ctrlSignal, inValid, hazardStall, flush,
    input  branch, jump, writeEN1, writeEN2, ifIDFlush, Op1Mux, Op2Mux,
           dataMemWR, dataMemRD, dirALUMux, wbMUX, aLUControl, stall
  );
endinterface

// File: rtl/pipe_control_unit.sv
// Pipeline control decoder with registered ID/EX controls and load-use / flush handling.
// Define CTRL_MULTICYCLE_EN to add the RUN/MCBUSY multi-cycle ALU sequencer.
//
// state  | meaning
// RUN    | decode one opcode per cycle
// MCBUSY | multi-cycle op in flight; hold aLUControl, keep stall high
module pipe_control_unit #(
  parameter int OPW       = 8,
  parameter int ALUW      = 4,
  parameter int MC_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  pipe_control_unit_if.slave bus
);
  localparam int B_BR  = 0;
  localparam int B_JMP = 1;
  localparam int B_WE1 = 2;
  localparam int B_IFF = 3;
  localparam int B_OP1 = 4;
  localparam int B_OP2 = 5;
  localparam int B_MWR = 6;
  localparam int B_MRD = 7;
  localparam int B_DIR = 8;
  localparam int B_WB  = 9;

  logic [9:0]      ctrl_d, ctrl_q;
  logic [ALUW-1:0] alu_d, alu_q;
  logic            stall_d, stall_q;

  logic [1:0]      op_class;
  logic            sub_bit;
  logic [ALUW-1:0] alu_field;

  assign op_class  = bus.ctrlSignal[OPW-1:OPW-2];
  assign sub_bit   = bus.ctrlSignal[OPW-3];
  assign alu_field = bus.ctrlSignal[ALUW-1:0];

`ifdef CTRL_MULTICYCLE_EN
  localparam int CW = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;
  localparam logic [CW-1:0] MC_LOAD = CW'(MC_CYCLES - 2);
  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] MCBUSY = 1'b1;

  logic [0:0]    state_d, state_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic          we2_d, we2_q;
`endif

  always_comb begin
    ctrl_d  = '0;
    alu_d   = '0;
    stall_d = 1'b0;
`ifdef CTRL_MULTICYCLE_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    we2_d   = 1'b0;
`endif
    if (bus.flush) begin
`ifdef CTRL_MULTICYCLE_EN
      state_d = RUN;
      cnt_d   = '0;
`endif
    end
`ifdef CTRL_MULTICYCLE_EN
    else if (state_q == MCBUSY) begin
      alu_d = alu_q;
      if (cnt_q == '0) begin
        ctrl_d[B_WE1] = 1'b1;
        we2_d         = 1'b1;
        state_d       = RUN;
      end else begin
        cnt_d   = cnt_q - 1'b1;
        stall_d = 1'b1;
      end
    end
`endif
    else if (bus.hazardStall) begin
      stall_d = 1'b1;
    end else if (bus.inValid) begin
      case (op_class)
        2'b00: begin
          if (bus.ctrlSignal != '0) begin
`ifdef CTRL_MULTICYCLE_EN
            if (alu_field == '1) begin
              alu_d   = alu_field;
              stall_d = 1'b1;
              cnt_d   = MC_LOAD;
              state_d = MCBUSY;
            end else begin
              ctrl_d[B_WE1] = 1'b1;
              alu_d         = alu_field;
            end
`else
            ctrl_d[B_WE1] = 1'b1;
            alu_d         = alu_field;
`endif
          end
        end
        2'b01: begin
          ctrl_d[B_WE1] = 1'b1;
          ctrl_d[B_OP2] = 1'b1;
          alu_d         = alu_field;
        end
        2'b10: begin
          ctrl_d[B_OP2] = 1'b1;
          if (!sub_bit) begin
            ctrl_d[B_MRD] = 1'b1;
            ctrl_d[B_WB]  = 1'b1;
            ctrl_d[B_WE1] = 1'b1;
          end else begin
            ctrl_d[B_MWR] = 1'b1;
            ctrl_d[B_DIR] = 1'b1;
          end
        end
        default: begin
          if (!sub_bit) begin
            ctrl_d[B_BR]  = 1'b1;
            ctrl_d[B_OP1] = 1'b1;
            alu_d         = alu_field;
          end else begin
            ctrl_d[B_JMP] = 1'b1;
            ctrl_d[B_IFF] = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      alu_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      alu_q   <= alu_d;
      stall_q <= stall_d;
    end
  end

`ifdef CTRL_MULTICYCLE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      we2_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we2_q   <= we2_d;
    end
  end
  assign bus.writeEN2 = we2_q;
`else
  assign bus.writeEN2 = 1'b0;
`endif

  assign bus.branch     = ctrl_q[B_BR];
  assign bus.jump       = ctrl_q[B_JMP];
  assign bus.writeEN1   = ctrl_q[B_WE1];
  assign bus.ifIDFlush  = ctrl_q[B_IFF];
  assign bus.Op1Mux     = ctrl_q[B_OP1];
  assign bus.Op2Mux     = ctrl_q[B_OP2];
  assign bus.dataMemWR  = ctrl_q[B_MWR];
  assign bus.dataMemRD  = ctrl_q[B_MRD];
  assign bus.dirALUMux  = ctrl_q[B_DIR];
  assign bus.wbMUX      = ctrl_q[B_WB];
  assign bus.aLUControl = alu_q;
  assign bus.stall      = stall_q;
endmodule

// File: tb/tb_pipe_control_unit.sv
// Self-checking bench for pipe_control_unit: directed scenarios then randomized
// traffic against a cycle-level reference model of the decode/stall rules.
module tb_pipe_control_unit;
  localparam int OPW       = 8;
  localparam int ALUW      = 4;
  localparam int MC_CYCLES = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_control_unit_if #(.OPW(OPW), .ALUW(ALUW)) bus ();

  pipe_control_unit #(.OPW(OPW), .ALUW(ALUW), .MC_CYCLES(MC_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // expected outputs: {branch,jump,we1,we2,ifIDFlush,op1,op2,memWR,memRD,dir,wb,alu[3:0],stall}
  logic            e_br, e_jmp, e_we1, e_we2, e_iff, e_op1, e_op2, e_mwr, e_mrd, e_dir, e_wb, e_stall;
  logic [ALUW-1:0] e_alu;
  int              mc_left = 0;
  logic [ALUW-1:0] mc_alu  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] dut_vec();
    return {bus.branch, bus.jump, bus.writeEN1, bus.writeEN2, bus.ifIDFlush, bus.Op1Mux,
            bus.Op2Mux, bus.dataMemWR, bus.dataMemRD, bus.dirALUMux, bus.wbMUX,
            bus.aLUControl, bus.stall};
  endfunction

  function automatic logic [15:0] exp_vec();
    return {e_br, e_jmp, e_we1, e_we2, e_iff, e_op1, e_op2, e_mwr, e_mrd, e_dir, e_wb,
            e_alu, e_stall};
  endfunction

  // mc_left counts edges remaining until the completion edge of a multi-cycle op
  task automatic model(input logic r, input logic [OPW-1:0] c, input logic iv,
                       input logic hz, input logic fl);
    int cls, a;
    bit s;
    {e_br, e_jmp, e_we1, e_we2, e_iff, e_op1, e_op2, e_mwr, e_mrd, e_dir, e_wb, e_stall} = '0;
    e_alu = '0;
    cls = int'(c) / (1 << (OPW - 2));
    s   = c[OPW-3];
    a   = int'(c) % (1 << ALUW);
    if (r || fl) begin
      mc_left = 0;
    end else if (mc_left > 0) begin
      mc_left--;
      e_alu = mc_alu;
      if (mc_left == 0) begin
        e_we1 = 1'b1;
        e_we2 = 1'b1;
      end else begin
        e_stall = 1'b1;
      end
    end else if (hz) begin
      e_stall = 1'b1;
    end else if (iv) begin
      if (cls == 0 && c != 0) begin
`ifdef CTRL_MULTICYCLE_EN
        if (a == (1 << ALUW) - 1) begin
          mc_left = MC_CYCLES - 1;
          mc_alu  = ALUW'(a);
          e_alu   = ALUW'(a);
          e_stall = 1'b1;
        end else begin
          e_we1 = 1'b1;
          e_alu = ALUW'(a);
        end
`else
        e_we1 = 1'b1;
        e_alu = ALUW'(a);
`endif
      end else if (cls == 1) begin
        e_we1 = 1'b1; e_op2 = 1'b1; e_alu = ALUW'(a);
      end else if (cls == 2 && !s) begin
        e_mrd = 1'b1; e_wb = 1'b1; e_we1 = 1'b1; e_op2 = 1'b1;
      end else if (cls == 2) begin
        e_mwr = 1'b1; e_dir = 1'b1; e_op2 = 1'b1;
      end else if (cls == 3 && !s) begin
        e_br = 1'b1; e_op1 = 1'b1; e_alu = ALUW'(a);
      end else if (cls == 3) begin
        e_jmp = 1'b1; e_iff = 1'b1;
      end
    end
  endtask

  task automatic step(input string tag, input logic r, input logic [OPW-1:0] c,
                      input logic iv, input logic hz, input logic fl);
    rst             = r;
    bus.ctrlSignal  = c;
    bus.inValid     = iv;
    bus.hazardStall = hz;
    bus.flush       = fl;
    @(posedge clk);
    model(r, c, iv, hz, fl);
    #1;
    check(tag, 32'(dut_vec()), 32'(exp_vec()));
  endtask

  logic [OPW-1:0] picks [8];

  initial begin
    picks[0] = 8'h00; picks[1] = 8'h0F; picks[2] = 8'h43; picks[3] = 8'h80;
    picks[4] = 8'hA0; picks[5] = 8'hC5; picks[6] = 8'hE0; picks[7] = 8'h27;

    // reset, with flush/hazard/opcode active to show rst dominates
    step("reset0", 1'b1, 8'h0F, 1'b1, 1'b1, 1'b1);
    step("reset1", 1'b1, 8'h43, 1'b1, 1'b0, 1'b0);
    check("reset_all_zero", 32'(dut_vec()), 32'h0);

    step("alu_imm_43", 1'b0, 8'h43, 1'b1, 1'b0, 1'b0);
    check("alu_imm_43_bits", 32'({bus.writeEN1, bus.Op2Mux, bus.aLUControl}), 32'h33);
    step("invalid_bubble", 1'b0, 8'h43, 1'b0, 1'b0, 1'b0);

`ifdef CTRL_MULTICYCLE_EN
    step("mc_accept", 1'b0, 8'h0F, 1'b1, 1'b0, 1'b0);
    check("mc_accept_stall", 32'({bus.stall, bus.writeEN1, bus.writeEN2, bus.aLUControl}), 32'h4F);
    step("mc_busy1", 1'b0, 8'h43, 1'b1, 1'b1, 1'b0);
    step("mc_busy2", 1'b0, 8'hE0, 1'b1, 1'b0, 1'b0);
    check("mc_busy2_stall", 32'({bus.stall, bus.writeEN1, bus.writeEN2, bus.aLUControl}), 32'h4F);
    step("mc_done", 1'b0, 8'hE0, 1'b1, 1'b0, 1'b0);
    check("mc_done_we", 32'({bus.stall, bus.writeEN1, bus.writeEN2, bus.aLUControl}), 32'h3F);
    step("after_mc", 1'b0, 8'hC5, 1'b1, 1'b0, 1'b0);

    step("mc2_accept", 1'b0, 8'h0F, 1'b1, 1'b0, 1'b0);
    step("mc2_busy", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step("mc2_flush", 1'b0, 8'h43, 1'b1, 1'b1, 1'b1);
    check("mc2_flush_zero", 32'(dut_vec()), 32'h0);
    step("mc2_after_flush", 1'b0, 8'h43, 1'b1, 1'b0, 1'b0);
    check("mc2_after_flush_bits", 32'({bus.writeEN1, bus.Op2Mux, bus.aLUControl, bus.stall}), 32'h66);
`else
    step("all_ones_alu", 1'b0, 8'h0F, 1'b1, 1'b0, 1'b0);
    check("all_ones_alu_bits", 32'({bus.stall, bus.writeEN1, bus.writeEN2, bus.aLUControl}), 32'h2F);
`endif

    step("jump_e0", 1'b0, 8'hE0, 1'b1, 1'b0, 1'b0);
    check("jump_e0_bits", 32'({bus.jump, bus.ifIDFlush}), 32'h3);
    step("branch_c5", 1'b0, 8'hC5, 1'b1, 1'b0, 1'b0);
    check("branch_c5_bits", 32'({bus.branch, bus.Op1Mux, bus.aLUControl}), 32'h35);
    step("load_hazard", 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);
    check("load_hazard_stall", 32'(dut_vec()), 32'h1);
    step("load_go", 1'b0, 8'h80, 1'b1, 1'b0, 1'b0);
    check("load_go_bits", 32'({bus.dataMemRD, bus.wbMUX, bus.writeEN1, bus.stall}), 32'hE);
    step("store_a0", 1'b0, 8'hA0, 1'b1, 1'b0, 1'b0);
    check("store_a0_bits", 32'({bus.dataMemWR, bus.dirALUMux, bus.writeEN1}), 32'h6);
    step("flush_over_hazard", 1'b0, 8'h43, 1'b1, 1'b1, 1'b1);
    check("flush_over_hazard_stall", 32'(bus.stall), 32'h0);
    step("nop_00", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic [OPW-1:0] c;
      c = ($urandom_range(0, 3) == 0) ? OPW'($urandom) : picks[$urandom_range(0, 7)];
      step("random", ($urandom_range(0, 49) == 0), c, ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pipe_control_unit.md
PIPE_CONTROL_UNIT -- requirements
Module: pipe_control_unit

Interface
REQ-001 The block SHALL have parameter OPW, default 8, meaning opcode width (>=4).
REQ-002 The block SHALL have parameter ALUW, default 4, meaning ALU control width (<=OPW-2).
REQ-003 The block SHALL have parameter MC_CYCLES, default 4, meaning multi-cycle op latency (>=2).
REQ-004 The block SHALL have these ports:
  clk  in  1  clock; one clock domain; all state SHALL update on the rising edge only.
  rst  in  1  synchronous, active-high reset.
  ctrlSignal  in  OPW  opcode from IF/ID.
  inValid  in  1  ctrlSignal valid.
  hazardStall  in  1  load-use stall from the hazard unit.
  flush  in  1  taken-branch flush from EX.
  branch, jump, writeEN1, writeEN2, ifIDFlush, Op1Mux, Op2Mux, dataMemWR, dataMemRD, dirALUMux, wbMUX  out  1  registered ID/EX controls.
  aLUControl  out  ALUW  registered ALU operation.
  stall  out  1  hold PC and IF/ID.

Function
REQ-005 Decode SHALL use class C=ctrlSignal[OPW-1:OPW-2], sub-bit S=ctrlSignal[OPW-3], and A=ctrlSignal[ALUW-1:0].
REQ-006 C=00 with ctrlSignal nonzero SHALL give writeEN1=1, aLUControl=A; ctrlSignal all-zero SHALL be a NOP with all controls 0.
REQ-007 C=01 SHALL give writeEN1=1, Op2Mux=1, aLUControl=A.
REQ-008 C=10, S=0 (load) SHALL give dataMemRD=1, wbMUX=1, writeEN1=1, Op2Mux=1, aLUControl=0.
REQ-009 C=10, S=1 (store) SHALL give dataMemWR=1, dirALUMux=1, Op2Mux=1, aLUControl=0.
REQ-010 C=11, S=0 SHALL give branch=1, Op1Mux=1, aLUControl=A; C=11, S=1 SHALL give jump=1, ifIDFlush=1.
REQ-011 Unspecified controls SHALL be 0; all outputs SHALL be registered with latency 1 cycle from the accepting edge.
REQ-012 inValid=0 SHALL register a bubble (all controls 0).
REQ-013 FSM states SHALL be RUN and MCBUSY; a multi-cycle op is C=00 with A all-ones.
REQ-014 RUN accepting a multi-cycle op SHALL register aLUControl=A with writeEN1=writeEN2=0, assert stall, load the counter with MC_CYCLES-2, and enter MCBUSY.
REQ-015 In MCBUSY, ctrlSignal, inValid and hazardStall SHALL be ignored, aLUControl held, and stall=1; the counter SHALL decrement each cycle.
REQ-016 In MCBUSY, when the counter is 0, the next edge SHALL set writeEN1=writeEN2=1 for one cycle, deassert stall, and return to RUN; stall is therefore high for exactly MC_CYCLES-1 cycles.
REQ-017 In RUN, hazardStall=1 SHALL register a bubble and assert stall for that cycle.
REQ-018 flush=1 SHALL register a bubble, deassert stall, clear the counter and force RUN, from either state.
REQ-019 When flush and hazardStall are both high, flush SHALL take priority.
REQ-020 The counter SHALL be $clog2(MC_CYCLES) bits wide (minimum 1) and SHALL never wrap below 0.

Reset
REQ-021 rst=1 at an edge SHALL zero every output, including stall and aLUControl, clear the counter and set RUN.
REQ-022 rst SHALL override flush, hazardStall and an in-progress MCBUSY; the first opcode SHALL be accepted on the edge after rst falls.

Configuration
REQ-023 With macro CTRL_MULTICYCLE_EN defined, REQ-013 to REQ-016 SHALL apply.
REQ-024 Without CTRL_MULTICYCLE_EN, the MCBUSY state and counter SHALL be absent; an A-all-ones C=00 op SHALL decode per REQ-006; writeEN2 SHALL be tied 0; and stall SHALL come only from REQ-017.

Verification
REQ-025 The bench SHALL cover these directed scenarios (OPW=8, ALUW=4, MC_CYCLES=4, CTRL_MULTICYCLE_EN defined):
  rst=1 for 2 cycles -> all outputs 0, stall=0.
  ctrlSignal=0x43, inValid=1 -> next cycle writeEN1=1, Op2Mux=1, aLUControl=0011, others 0.
  ctrlSignal=0x0F at edge k -> stall=1 at edges k+1..k+3 with writeEN1/2=0; at edge k+4 writeEN1=writeEN2=1, stall=0, aLUControl=1111 throughout.
  0x0F accepted, flush=1 at edge k+2 -> at k+2 all controls 0, stall=0; a 0x43 at k+3 is decoded normally at k+4.
  ctrlSignal=0xE0 -> one cycle jump=1, ifIDFlush=1; 0xC5 -> branch=1, Op1Mux=1, aLUControl=0101.
  0x80 with hazardStall=1 -> bubble with stall=1; next cycle hazardStall=0 -> dataMemRD=1, wbMUX=1, writeEN1=1; 0xA0 -> dataMemWR=1, dirALUMux=1.
